buf_arbiter: RTL and testbench

- Shares the single register-array buffer port between two requesters: requester 0 is the Wishbone interface side, requester 1 is the SPI engine side.
- Sequences each buffer access as request, then buffer ACK, then one-cycle response to the requester.
- Arbitrates round-robin when both sides request at once.
- Guards against a hung buffer with a timeout that terminates the access with an error.

---
 rtl/buf_arbiter_if.sv | 52 +++++
 rtl/buf_arbiter.sv | 103 ++++++++++
 tb/tb_buf_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/buf_arbiter_if.sv
// rtl/buf_arbiter_if.sv - requester and buffer port bundle for buf_arbiter
interface buf_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          R0_REQ;
    logic          R0_WR;
    logic [AW-1:0] R0_ADDR;
    logic [DW-1:0] R0_DAT_I;
    logic [DW-1:0] R0_DAT_O;
    logic          R0_ACK;
    logic          R0_ERR;

    logic          R1_REQ;
    logic          R1_WR;
    logic [AW-1:0] R1_ADDR;
    logic [DW-1:0] R1_DAT_I;
    logic [DW-1:0] R1_DAT_O;
    logic          R1_ACK;
    logic          R1_ERR;

    logic          BUF_REQ;
    logic          BUF_WR;
    logic [AW-1:0] BUF_ADDR_O;
    logic [DW-1:0] BUF_DATA_O;
    logic [DW-1:0] BUF_DATA_I;
    logic          BUF_ACK;
    logic          BUF_ERR;

    logic [1:0]    GNT;

    // master is the arbiter, slave is the requesters plus the buffer
    modport master (
        input  R0_REQ, R0_WR, R0_ADDR, R0_DAT_I,
        output R0_DAT_O, R0_ACK, R0_ERR,
        input  R1_REQ, R1_WR, R1_ADDR, R1_DAT_I,
        output R1_DAT_O, R1_ACK, R1_ERR,
        output BUF_REQ, BUF_WR, BUF_ADDR_O, BUF_DATA_O,
        input  BUF_DATA_I, BUF_ACK, BUF_ERR,
        output GNT
    );

    modport slave (
        output R0_REQ, R0_WR, R0_ADDR, R0_DAT_I,
        input  R0_DAT_O, R0_ACK, R0_ERR,
        output R1_REQ, R1_WR, R1_ADDR, R1_DAT_I,
        input  R1_DAT_O, R1_ACK, R1_ERR,
        input  BUF_REQ, BUF_WR, BUF_ADDR_O, BUF_DATA_O,
        output BUF_DATA_I, BUF_ACK, BUF_ERR,
        input  GNT
    );
endinterface

// File: rtl/buf_arbiter.sv
// rtl/buf_arbiter.sv - two-requester round-robin arbiter for the buffer port with access timeout
module buf_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic           WB_CLK_I,
    input  logic           WB_RST_N_I,
    buf_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          owner;
    logic          win;
    logic [DW-1:0] resp_dat;
    logic          resp_err;

    // On a tie the requester not served last wins; otherwise whoever asks
    always_comb begin
        win = (bus.R0_REQ && bus.R1_REQ) ? ~last : bus.R1_REQ;
    end

    // Timeout path returns zero data with error; writes never return data
    always_comb begin
        resp_dat = '0;
        resp_err = 1'b1;
        if (bus.BUF_ACK) begin
            resp_dat = bus.BUF_WR ? '0 : bus.BUF_DATA_I;
            resp_err = bus.BUF_ERR;
        end
    end

    always_ff @(posedge WB_CLK_I) begin
        if (!WB_RST_N_I) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 1'b1;
            owner          <= 1'b0;
            bus.BUF_REQ    <= 1'b0;
            bus.BUF_WR     <= 1'b0;
            bus.BUF_ADDR_O <= '0;
            bus.BUF_DATA_O <= '0;
            bus.GNT        <= 2'b00;
            bus.R0_DAT_O   <= '0;
            bus.R0_ACK     <= 1'b0;
            bus.R0_ERR     <= 1'b0;
            bus.R1_DAT_O   <= '0;
            bus.R1_ACK     <= 1'b0;
            bus.R1_ERR     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.R0_REQ || bus.R1_REQ) begin
                        owner          <= win;
                        last           <= win;
                        bus.BUF_REQ    <= 1'b1;
                        bus.BUF_WR     <= win ? bus.R1_WR    : bus.R0_WR;
                        bus.BUF_ADDR_O <= win ? bus.R1_ADDR  : bus.R0_ADDR;
                        bus.BUF_DATA_O <= win ? bus.R1_DAT_I : bus.R0_DAT_I;
                        bus.GNT        <= win ? 2'b10 : 2'b01;
                        cnt            <= '0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.BUF_ACK || cnt == CNT_LAST) begin
                        bus.BUF_REQ <= 1'b0;
                        if (owner) begin
                            bus.R1_DAT_O <= resp_dat;
                            bus.R1_ERR   <= resp_err;
                            bus.R1_ACK   <= 1'b1;
                        end else begin
                            bus.R0_DAT_O <= resp_dat;
                            bus.R0_ERR   <= resp_err;
                            bus.R0_ACK   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.R0_ACK     <= 1'b0;
                    bus.R0_ERR     <= 1'b0;
                    bus.R1_ACK     <= 1'b0;
                    bus.R1_ERR     <= 1'b0;
                    bus.GNT        <= 2'b00;
                    bus.BUF_WR     <= 1'b0;
                    bus.BUF_ADDR_O <= '0;
                    bus.BUF_DATA_O <= '0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_buf_arbiter.sv
// tb/tb_buf_arbiter.sv - directed vector bench for buf_arbiter
module tb_buf_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    buf_arbiter_if #(.DW(32), .AW(8)) bus ();

    buf_arbiter #(.DW(32), .AW(8), .TIMEOUT(16), .CW(5)) dut (
        .WB_CLK_I   (clk),
        .WB_RST_N_I (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic        who;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        berr;
        int          k;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.R0_REQ = 0; bus.R0_WR = 0; bus.R0_ADDR = 0; bus.R0_DAT_I = 0;
        bus.R1_REQ = 0; bus.R1_WR = 0; bus.R1_ADDR = 0; bus.R1_DAT_I = 0;
        bus.BUF_ACK = 0; bus.BUF_ERR = 0; bus.BUF_DATA_I = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cycles;
        int   other;
        logic done;
        logic my_ack;
        @(negedge clk);
        if (v.who) begin
            bus.R1_REQ = 1; bus.R1_WR = v.wr; bus.R1_ADDR = v.addr; bus.R1_DAT_I = v.wdat;
        end else begin
            bus.R0_REQ = 1; bus.R0_WR = v.wr; bus.R0_ADDR = v.addr; bus.R0_DAT_I = v.wdat;
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d gnt", idx), bus.GNT, v.who ? 2'b10 : 2'b01);
        chk($sformatf("v%0d buf_req", idx), bus.BUF_REQ, 1);
        chk($sformatf("v%0d buf_wr", idx), bus.BUF_WR, v.wr);
        chk($sformatf("v%0d buf_addr", idx), bus.BUF_ADDR_O, v.addr);
        chk($sformatf("v%0d buf_data", idx), bus.BUF_DATA_O, v.wdat);
        cycles = 1;
        other  = 0;
        done   = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (v.k != 0 && cycles == v.k) begin
                bus.BUF_ACK = 1; bus.BUF_DATA_I = v.rdat; bus.BUF_ERR = v.berr;
            end else begin
                bus.BUF_ACK = 0; bus.BUF_DATA_I = 32'h5A5A_5A5A; bus.BUF_ERR = 0;
            end
            @(posedge clk); #1;
            my_ack = v.who ? bus.R1_ACK : bus.R0_ACK;
            if (v.who ? bus.R0_ACK : bus.R1_ACK) other++;
            if (my_ack) done = 1;
            else if (bus.BUF_REQ) cycles++;
        end
        chk($sformatf("v%0d ack_seen", idx), done, 1);
        chk($sformatf("v%0d buf_req_cycles", idx), cycles, v.exp_cycles);
        chk($sformatf("v%0d dat_o", idx), v.who ? bus.R1_DAT_O : bus.R0_DAT_O, v.exp_dat);
        chk($sformatf("v%0d err", idx), v.who ? bus.R1_ERR : bus.R0_ERR, v.exp_err);
        chk($sformatf("v%0d buf_req_off", idx), bus.BUF_REQ, 0);
        chk($sformatf("v%0d other_ack", idx), other, 0);
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        chk($sformatf("v%0d ack_pulse", idx), v.who ? bus.R1_ACK : bus.R0_ACK, 0);
        chk($sformatf("v%0d gnt_idle", idx), bus.GNT, 0);
        chk($sformatf("v%0d addr_idle", idx), bus.BUF_ADDR_O, 0);
        chk($sformatf("v%0d dat_hold", idx), v.who ? bus.R1_DAT_O : bus.R0_DAT_O, v.exp_dat);
    endtask

    task automatic round_robin();
        int   order [4];
        int   n = 0;
        int   bad = 0;
        int   grants = 0;
        logic [1:0] prev_gnt = 2'b00;
        apply_reset();
        @(negedge clk);
        bus.R0_REQ = 1; bus.R0_ADDR = 8'h30;
        bus.R1_REQ = 1; bus.R1_ADDR = 8'h31;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            bus.BUF_ACK    = bus.BUF_REQ;
            bus.BUF_DATA_I = {24'h0, bus.BUF_ADDR_O};
            @(posedge clk); #1;
            if (bus.GNT == 2'b11) bad++;
            if (bus.R0_ACK && bus.R1_ACK) bad++;
            if (prev_gnt == 2'b00 && bus.GNT != 2'b00) grants++;
            prev_gnt = bus.GNT;
            if (bus.R0_ACK) begin order[n] = 0; n++; end
            if (bus.R1_ACK && n < 4) begin order[n] = 1; n++; end
        end
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        chk("rr acks", n, 4);
        chk("rr grants", grants, 4);
        chk("rr bad", bad, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr order%0d", i), order[i], i % 2);
        chk("rr r1_dat", bus.R1_DAT_O, 32'h31);
        chk("rr gnt_idle", bus.GNT, 0);
    endtask

    task automatic reset_mid_access();
        int spurious = 0;
        @(negedge clk);
        bus.R0_REQ = 1; bus.R0_ADDR = 8'h44;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        chk("rst buf_req", bus.BUF_REQ, 0);
        chk("rst gnt", bus.GNT, 0);
        chk("rst r0_ack", bus.R0_ACK, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.R0_ACK || bus.R1_ACK || bus.BUF_REQ) spurious++;
        end
        chk("rst no_ack", spurious, 0);
        @(negedge clk);
        bus.R0_REQ = 1; bus.R0_ADDR = 8'h50;
        bus.R1_REQ = 1; bus.R1_ADDR = 8'h51;
        @(posedge clk); #1;
        chk("rst tie_gnt", bus.GNT, 2'b01);
        @(negedge clk);
        bus.R0_REQ = 0; bus.R1_REQ = 0;
        bus.BUF_ACK = 1; bus.BUF_DATA_I = 32'h600D_F00D;
        @(posedge clk); #1;
        chk("rst drop_ack", bus.R0_ACK, 1);
        chk("rst drop_r1", bus.R1_ACK, 0);
        chk("rst drop_dat", bus.R0_DAT_O, 32'h600D_F00D);
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        chk("rst resp_idle", bus.GNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          who wr addr   wdat          rdat          berr k   exp_dat       err cyc
        vecs[0] = '{0, 1, 8'h10, 32'hDEADBEEF, 32'hAAAA5555, 0,   2,  32'h0,        0,  2};
        vecs[1] = '{1, 0, 8'h22, 32'h0,        32'h12345678, 0,   1,  32'h12345678, 0,  1};
        vecs[2] = '{0, 0, 8'h05, 32'h0,        32'h0,        0,   0,  32'h0,        1,  16};
        vecs[3] = '{0, 0, 8'h06, 32'h0,        32'hCAFEF00D, 0,   3,  32'hCAFEF00D, 0,  3};
        vecs[4] = '{0, 0, 8'h7F, 32'h0,        32'h0BADC0DE, 1,   16, 32'h0BADC0DE, 1,  16};
        vecs[5] = '{1, 1, 8'hFF, 32'h11223344, 32'h99999999, 1,   5,  32'h0,        1,  5};

        clear_inputs();
        apply_reset();
        #1;
        chk("reset buf_req", bus.BUF_REQ, 0);
        chk("reset gnt", bus.GNT, 0);
        chk("reset acks", {bus.R0_ACK, bus.R1_ACK, bus.R0_ERR, bus.R1_ERR}, 0);
        chk("reset bufbus", {bus.BUF_WR, bus.BUF_ADDR_O, bus.BUF_DATA_O}, 0);
        chk("reset dat_o", {bus.R0_DAT_O, bus.R1_DAT_O}, 0);

        for (int i = 0; i < 6; i++)
            run_vec(i, vecs[i]);

        round_robin();
        reset_mid_access();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
